// File: rtl/dff_elastic_pipe.sv
// dff_elastic_pipe
//   DEPTH-stage, WIDTH-bit elastic pipeline register built from edge-triggered flops.
//   Every stage has its own valid bit. A stage loads from its upstream neighbour whenever
//   it is empty or its downstream neighbour can move. This lets bubbles collapse while the
//   output is stalled.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears valid bits, data and occupancy
//   flush      synchronous clear of all valid bits (data left as is), beats any transfer
//   in_valid   upstream word valid
//   in_data    upstream word
//   in_ready   pipe can take in_data this cycle (never depends on in_valid)
//   out_valid  last stage holds a valid word
//   out_data   word in the last stage
//   out_ready  downstream takes out_data this cycle
//   occupancy  registered count of valid stages, 0..DEPTH

module dff_elastic_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  // Stage state, index 0 is the input stage and DEPTH-1 is the output stage
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // rdy[i]: stage i may load this edge; rdy[DEPTH] is the downstream ready
  logic [DEPTH:0]   rdy;

  // What each stage would load: the input port for stage 0, the previous stage otherwise
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];

  logic xfer_in, xfer_out;

  // Ready chain. Built with a running term so the vector is only ever written here,
  // which keeps the chain free of self-reads.
  always_comb begin
    logic chain;
    chain      = out_ready;
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !valid_q[i] || chain;
      rdy[i] = chain;
    end
  end

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  assign xfer_in  = in_valid && rdy[0];
  assign xfer_out = valid_q[DEPTH-1] && out_ready;

  // Stage next state. Data only moves alongside a valid word, so bubbles never
  // overwrite the data a stage already holds.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          valid_d[i] = src_valid[i];
          if (src_valid[i]) begin
            data_d[i] = src_data[i];
          end
        end
      end
    end
  end

  // Occupancy tracks popcount(valid) incrementally
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(xfer_in) - CNT_W'(xfer_out);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = cnt_q;

endmodule

// File: tb/tb_dff_elastic_pipe.sv
// Bench for dff_elastic_pipe: a WIDTH=8/DEPTH=4 instance driven by directed steps, then a
// WIDTH=1/DEPTH=1 instance driven randomly. Accepted words go into a queue and are compared
// when the pipe hands them out.

module tb_dff_elastic_pipe;

  logic clk;
  logic rst_n;

  // DUT A: WIDTH=8, DEPTH=4
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_occupancy;

  // DUT B: WIDTH=1, DEPTH=1
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0] b_in_data, b_out_data;
  logic [0:0] b_occupancy;

  int checks;
  int failures;
  int a_emitted;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  dff_elastic_pipe #(.WIDTH(8), .DEPTH(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_data   (a_in_data),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_data  (a_out_data),
    .out_ready (a_out_ready),
    .occupancy (a_occupancy)
  );

  dff_elastic_pipe #(.WIDTH(1), .DEPTH(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_ready (b_out_ready),
    .occupancy (b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of DUT A: note handshakes with inputs settled, then advance past the edge
  task automatic tick_a();
    logic xin, xout;
    logic [31:0] exp_word;
    #1;
    xin  = a_in_valid && a_in_ready;
    xout = a_out_valid && a_out_ready;
    if (a_flush) begin
      q_a.delete();
    end else begin
      if (xout) begin
        exp_word = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD_BEEF;
        chk("a_out_data", {24'h0, a_out_data}, exp_word);
        a_emitted++;
      end
      if (xin) q_a.push_back({24'h0, a_in_data});
    end
    @(posedge clk);
    #1;
    chk("a_occupancy", {29'h0, a_occupancy}, q_a.size());
  endtask

  task automatic tick_b();
    logic xin, xout;
    logic [31:0] exp_word;
    #1;
    chk("b_in_ready", {31'h0, b_in_ready}, {31'h0, (!b_out_valid || b_out_ready)});
    xin  = b_in_valid && b_in_ready;
    xout = b_out_valid && b_out_ready;
    if (xout) begin
      exp_word = (q_b.size() > 0) ? q_b.pop_front() : 32'hDEAD_BEEF;
      chk("b_out_data", {31'h0, b_out_data}, exp_word);
    end
    if (xin) q_b.push_back({31'h0, b_in_data});
    @(posedge clk);
    #1;
    chk("b_occupancy", {31'h0, b_occupancy}, q_b.size());
  endtask

  task automatic drain_a(input int budget);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (q_a.size() == 0 && !a_out_valid) break;
      tick_a();
    end
    chk("a_drained", {29'h0, a_occupancy}, 32'd0);
  endtask

  initial begin
    int idx;
    checks    = 0;
    failures  = 0;
    a_emitted = 0;
    rst_n       = 1'b0;
    a_flush     = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = 8'h00;
    a_out_ready = 1'b0;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = 1'b0;
    b_out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'h0, a_out_valid}, 32'd0);
    chk("rst_out_data", {24'h0, a_out_data}, 32'd0);
    chk("rst_in_ready", {31'h0, a_in_ready}, 32'd1);
    chk("rst_occupancy", {29'h0, a_occupancy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: three words back to back, first appears after the 4th edge
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data = 8'h11; tick_a();
    a_in_data = 8'h22; tick_a();
    a_in_data = 8'h33; tick_a();
    chk("t1_not_yet_valid", {31'h0, a_out_valid}, 32'd0);
    chk("t1_occ_peak", {29'h0, a_occupancy}, 32'd3);
    a_in_valid = 1'b0;
    tick_a();
    chk("t1_valid_4th_edge", {31'h0, a_out_valid}, 32'd1);
    chk("t1_first_word", {24'h0, a_out_data}, 32'h11);
    chk("t1_occ_still_3", {29'h0, a_occupancy}, 32'd3);
    drain_a(10);
    chk("t1_emitted", a_emitted, 32'd3);

    // 2: stall fills the pipe, then release streams everything in order
    a_emitted   = 0;
    a_out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = (idx < 6);
      a_in_data  = 8'hA0 + 8'(idx);
      #1;
      if (a_in_valid && a_in_ready) idx++;
      tick_a();
    end
    chk("t2_accepted", idx, 32'd4);
    chk("t2_full_in_ready", {31'h0, a_in_ready}, 32'd0);
    chk("t2_full_occ", {29'h0, a_occupancy}, 32'd4);
    chk("t2_held_data", {24'h0, a_out_data}, 32'hA0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (idx >= 6) break;
      a_in_valid = 1'b1;
      a_in_data  = 8'hA0 + 8'(idx);
      #1;
      if (a_in_ready) idx++;
      tick_a();
    end
    drain_a(20);
    chk("t2_emitted", a_emitted, 32'd6);

    // 3: bubbles collapse behind a stalled output
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h01; tick_a();
    a_in_valid = 1'b0; tick_a(); tick_a();
    a_in_valid = 1'b1; a_in_data = 8'h02; tick_a();
    a_in_valid = 1'b0;
    repeat (4) tick_a();
    chk("t3_occ", {29'h0, a_occupancy}, 32'd2);
    chk("t3_in_ready", {31'h0, a_in_ready}, 32'd1);
    chk("t3_head", {24'h0, a_out_data}, 32'h01);
    drain_a(10);

    // 4: flush drops contents and the word offered alongside it
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 8'h61; tick_a();
    a_in_data = 8'h62; tick_a();
    a_in_data = 8'h63; tick_a();
    a_flush = 1'b1; a_in_data = 8'h55; tick_a();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("t4_occ", {29'h0, a_occupancy}, 32'd0);
    chk("t4_out_valid", {31'h0, a_out_valid}, 32'd0);
    a_out_ready = 1'b1;
    repeat (6) tick_a();
    chk("t4_never_emitted", {31'h0, a_out_valid}, 32'd0);

    // 5: asynchronous reset between edges
    a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_data = 8'hC0 + 8'(i);
      tick_a();
    end
    chk("t5_pre_valid", {31'h0, a_out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", {31'h0, a_out_valid}, 32'd0);
    chk("t5_out_data", {24'h0, a_out_data}, 32'd0);
    chk("t5_occ", {29'h0, a_occupancy}, 32'd0);
    chk("t5_in_ready", {31'h0, a_in_ready}, 32'd1);
    q_a.delete();
    a_in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_after_release", {29'h0, a_occupancy}, 32'd0);

    // 6: DEPTH=1 WIDTH=1 random handshakes
    for (int i = 0; i < 200; i++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_data   = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      tick_b();
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    tick_b();
    tick_b();
    chk("t6_drained", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
